// File: rtl/openhmc_rf_arb_pkg.sv
// Shared types and helpers for the openHMC register-file port arbiter.
package openhmc_rf_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } rf_arb_state_t;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/openhmc_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, wrapping at N.
module openhmc_rr_arbiter
  import openhmc_rf_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = width_of(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest pending one wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    for (int i = N; i >= 1; i--) begin
      idx = IW'((int'(last_grant) + i) % N);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/openhmc_rf_arbiter.sv
// Round-robin arbiter serialising NUM_REQ requesters onto the single openHMC RF port,
// one access in flight, with a watchdog on rf_access_complete.
module openhmc_rf_arbiter
  import openhmc_rf_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int HMC_RF_AWIDTH  = 4,
  parameter int HMC_RF_WWIDTH  = 64,
  parameter int HMC_RF_RWIDTH  = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                               clk_hmc,
  input  logic                               res_n_hmc,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0]                 req_write,
  input  logic [NUM_REQ*HMC_RF_AWIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*HMC_RF_WWIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  output logic [HMC_RF_RWIDTH-1:0]           rsp_rdata,
  output logic                               rsp_invalid,
  output logic                               rsp_timeout,
  output logic [HMC_RF_AWIDTH-1:0]           rf_address,
  output logic [HMC_RF_WWIDTH-1:0]           rf_write_data,
  output logic                               rf_read_en,
  output logic                               rf_write_en,
  input  logic [HMC_RF_RWIDTH-1:0]           rf_read_data,
  input  logic                               rf_access_complete,
  input  logic                               rf_invalid_address
);

  localparam int IDX_W = width_of(NUM_REQ);
  localparam int CNT_W = width_of(TIMEOUT_CYCLES + 1);

  rf_arb_state_t             state, state_nxt;
  logic [NUM_REQ-1:0]        grant;
  logic [IDX_W-1:0]          grant_idx;
  logic [IDX_W-1:0]          last_grant;
  logic [IDX_W-1:0]          owner;
  logic                      wr_q;
  logic [CNT_W-1:0]          cnt;
  logic                      expire;
  logic                      sel_write;
  logic [HMC_RF_AWIDTH-1:0]  sel_addr;
  logic [HMC_RF_WWIDTH-1:0]  sel_wdata;

  openhmc_rr_arbiter #(.N(NUM_REQ), .IW(IDX_W)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  // Mux out the winner's request fields with constant slices only.
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == IDX_W'(k)) begin
        sel_write = req_write[k];
        sel_addr  = req_addr[k*HMC_RF_AWIDTH +: HMC_RF_AWIDTH];
        sel_wdata = req_wdata[k*HMC_RF_WWIDTH +: HMC_RF_WWIDTH];
      end
    end
  end

  assign expire = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (|req_valid) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = rf_access_complete ? ST_RESP : ST_WAIT;
      ST_WAIT:  if (rf_access_complete || expire) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs are held low while reset is asserted so nobody sees a phantom accept.
  assign req_ready   = (res_n_hmc && state == ST_IDLE) ? grant : '0;
  assign rsp_valid   = (res_n_hmc && state == ST_RESP) ? (NUM_REQ'(1) << owner) : '0;
  assign rf_read_en  = res_n_hmc && (state == ST_ISSUE) && !wr_q;
  assign rf_write_en = res_n_hmc && (state == ST_ISSUE) &&  wr_q;

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous, sampled on the clock edge.
  always_ff @(posedge clk_hmc) begin
    if (!res_n_hmc) begin
      state         <= ST_IDLE;
      last_grant    <= IDX_W'(NUM_REQ - 1);
      owner         <= '0;
      wr_q          <= 1'b0;
      cnt           <= '0;
      rf_address    <= '0;
      rf_write_data <= '0;
      rsp_rdata     <= '0;
      rsp_invalid   <= 1'b0;
      rsp_timeout   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (|req_valid) begin
            owner         <= grant_idx;
            wr_q          <= sel_write;
            rf_address    <= sel_addr;
            rf_write_data <= sel_wdata;
          end
        end
        ST_ISSUE, ST_WAIT: begin
          if (rf_access_complete) begin
            rsp_rdata   <= wr_q ? '0 : rf_read_data;
            rsp_invalid <= rf_invalid_address;
            rsp_timeout <= 1'b0;
          end else if (state == ST_WAIT && expire) begin
            rsp_rdata   <= '0;
            rsp_invalid <= 1'b1;
            rsp_timeout <= 1'b1;
          end
          if (state == ST_WAIT && cnt != '1) cnt <= cnt + CNT_W'(1);
        end
        ST_RESP: begin
          last_grant <= owner;
          cnt        <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_openhmc_rf_arbiter.sv
// Directed bench for openhmc_rf_arbiter: two requesters, watchdog shortened to 8 cycles.
module tb_openhmc_rf_arbiter;

  logic         clk_hmc = 1'b0;
  logic         res_n_hmc;
  logic [1:0]   req_valid;
  logic [1:0]   req_write;
  logic [7:0]   req_addr;
  logic [127:0] req_wdata;
  logic [1:0]   req_ready;
  logic [1:0]   rsp_valid;
  logic [63:0]  rsp_rdata;
  logic         rsp_invalid;
  logic         rsp_timeout;
  logic [3:0]   rf_address;
  logic [63:0]  rf_write_data;
  logic         rf_read_en;
  logic         rf_write_en;
  logic [63:0]  rf_read_data;
  logic         rf_access_complete;
  logic         rf_invalid_address;

  int n_checks = 0;
  int n_fail   = 0;
  int n_viol   = 0;

  always #5 clk_hmc = ~clk_hmc;

  openhmc_rf_arbiter #(
    .NUM_REQ(2), .HMC_RF_AWIDTH(4), .HMC_RF_WWIDTH(64), .HMC_RF_RWIDTH(64), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_hmc(clk_hmc), .res_n_hmc(res_n_hmc),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_invalid(rsp_invalid), .rsp_timeout(rsp_timeout),
    .rf_address(rf_address), .rf_write_data(rf_write_data),
    .rf_read_en(rf_read_en), .rf_write_en(rf_write_en), .rf_read_data(rf_read_data),
    .rf_access_complete(rf_access_complete), .rf_invalid_address(rf_invalid_address)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_hmc);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  // Invariants sampled on the falling edge throughout the run.
  always @(negedge clk_hmc) begin
    if (rf_read_en && rf_write_en) n_viol++;
    if (!$onehot0(req_ready)) n_viol++;
    if (!$onehot0(rsp_valid)) n_viol++;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    res_n_hmc = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    rf_read_data = '0; rf_access_complete = 1'b0; rf_invalid_address = 1'b0;
    step(); step(); settle();
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_en", {rf_read_en, rf_write_en}, 0);
    check("rst_rf_address", rf_address, 0);
    check("rst_rsp", {rsp_rdata[3:0], rsp_invalid, rsp_timeout}, 0);

    // 1: read req0 addr 3, RF completes 3 cycles after read_en
    res_n_hmc = 1'b1; req_valid = 2'b01; req_write = 2'b00; req_addr = 8'h03;
    settle();
    check("t1_ready", req_ready, 2'b01);
    step(); req_valid = 2'b00; settle();
    check("t1_read_en", {rf_read_en, rf_write_en}, 2'b10);
    check("t1_addr", rf_address, 4'h3);
    step(); settle();
    check("t1_en_pulse", rf_read_en, 0);
    step();
    step(); rf_access_complete = 1'b1; rf_read_data = 64'hDEAD_BEEF;
    step(); rf_access_complete = 1'b0; rf_read_data = '0; settle();
    check("t1_rsp_valid", rsp_valid, 2'b01);
    check("t1_rdata", rsp_rdata, 64'hDEAD_BEEF);
    check("t1_flags", {rsp_invalid, rsp_timeout}, 0);
    step(); settle();
    check("t1_rsp_pulse", rsp_valid, 0);

    // 2: both valid continuously from reset, grants alternate starting at 0
    res_n_hmc = 1'b0; req_valid = 2'b11;
    step(); settle();
    check("t2_rst_ready", req_ready, 0);
    res_n_hmc = 1'b1; settle();
    for (int i = 0; i < 4; i++) begin
      logic [1:0] exp_g;
      exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
      check("t2_grant", req_ready, exp_g);
      step(); rf_access_complete = 1'b1; settle();
      check("t2_issue_ready", req_ready, 0);
      step(); rf_access_complete = 1'b0; settle();
      check("t2_rsp_valid", rsp_valid, exp_g);
      step(); settle();
    end
    req_valid = 2'b00;
    step();

    // 3: write req1 addr F, RF flags invalid address
    req_valid = 2'b10; req_write = 2'b10; req_addr = 8'hF0;
    req_wdata = {64'h0123_4567_89AB_CDEF, 64'h0};
    settle();
    check("t3_ready", req_ready, 2'b10);
    step(); req_valid = 2'b00; rf_read_data = 64'h1234; settle();
    check("t3_write_en", {rf_read_en, rf_write_en}, 2'b01);
    check("t3_addr", rf_address, 4'hF);
    check("t3_wdata", rf_write_data, 64'h0123_4567_89AB_CDEF);
    step(); rf_access_complete = 1'b1; rf_invalid_address = 1'b1;
    step(); rf_access_complete = 1'b0; rf_invalid_address = 1'b0; settle();
    check("t3_rsp_valid", rsp_valid, 2'b10);
    check("t3_flags", {rsp_invalid, rsp_timeout}, 2'b10);
    check("t3_rdata", rsp_rdata, 0);
    step(); req_write = 2'b00;

    // 4: RF never completes, watchdog fires on WAIT cycle 8
    req_valid = 2'b01; req_addr = 8'h05; rf_read_data = 64'h5555;
    settle();
    check("t4_ready", req_ready, 2'b01);
    step(); req_valid = 2'b00;
    for (int w = 1; w <= 8; w++) step();
    settle();
    check("t4_no_early_rsp", rsp_valid, 0);
    step(); settle();
    check("t4_rsp_valid", rsp_valid, 2'b01);
    check("t4_flags", {rsp_invalid, rsp_timeout}, 2'b11);
    check("t4_rdata", rsp_rdata, 0);
    step(); rf_access_complete = 1'b1; settle();
    check("t4_late_rsp", rsp_valid, 0);
    check("t4_late_en", {rf_read_en, rf_write_en}, 0);
    step(); rf_access_complete = 1'b0; settle();
    check("t4_late_hold", {rsp_valid, rsp_timeout}, 3'b001);

    // 5a: completion in ISSUE gives rsp_valid two cycles after req_ready
    req_valid = 2'b01; settle();
    check("t5a_ready", req_ready, 2'b01);
    step(); req_valid = 2'b00; rf_access_complete = 1'b1; rf_read_data = 64'hA5; settle();
    check("t5a_issue_rsp", rsp_valid, 0);
    step(); rf_access_complete = 1'b0; settle();
    check("t5a_rsp_valid", rsp_valid, 2'b01);
    check("t5a_rdata", rsp_rdata, 64'hA5);
    step();

    // 5b: completion on the expiry cycle wins over the timeout
    req_valid = 2'b01; settle();
    check("t5b_ready", req_ready, 2'b01);
    step(); req_valid = 2'b00;
    for (int w = 1; w <= 8; w++) step();
    rf_access_complete = 1'b1; rf_read_data = 64'h77;
    step(); rf_access_complete = 1'b0; settle();
    check("t5b_rsp_valid", rsp_valid, 2'b01);
    check("t5b_flags", {rsp_invalid, rsp_timeout}, 0);
    check("t5b_rdata", rsp_rdata, 64'h77);
    step();

    // 6: reset during WAIT aborts silently; req0 served first afterwards
    req_valid = 2'b01; settle();
    check("t6_ready", req_ready, 2'b01);
    step(); req_valid = 2'b00;
    step(); res_n_hmc = 1'b0; req_valid = 2'b11;
    step(); settle();
    check("t6_rst_outs", {rsp_valid, req_ready, rf_read_en, rf_write_en}, 0);
    check("t6_rst_regs", {rf_address, rsp_rdata[7:0], rsp_invalid, rsp_timeout}, 0);
    step(); res_n_hmc = 1'b1; settle();
    check("t6_first_grant", req_ready, 2'b01);
    check("t6_no_rsp", rsp_valid, 0);
    req_valid = 2'b00;
    step(); rf_access_complete = 1'b1;
    step(); rf_access_complete = 1'b0;
    step(); step();

    check("invariants", n_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
